// File: rtl/inst_fetch.sv
// inst_fetch: IF stage of the five-stage MIPS core.
// Owns the PC and runs a variable-latency request/ready fetch against the
// instruction ROM/bus. It honours one branch delay slot, stalls, and
// exception/ERET flushes, and uses a one-entry hold buffer for words that
// return while decode is stalled.
//
// Handshake: a fetch is outstanding while o_rom_en=1. It completes in the
// cycle i_rom_ready=1, and i_rom_rdata is valid in that same cycle.
// o_rom_addr must not change while o_rom_en=1 and i_rom_ready=0.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  input  logic        i_branch_flag,
  input  logic [31:0] i_branch_addr,
  output logic        o_rom_en,
  output logic [31:0] o_rom_addr,
  input  logic        i_rom_ready,
  input  logic [31:0] i_rom_rdata,
  output logic        o_id_valid,
  output logic [31:0] o_id_addr,
  output logic [31:0] o_id_inst,
  output logic        o_id_adel,
  output logic [1:0]  o_dbg_state
);

  localparam logic [1:0] S_REQ  = 2'd0;  // request pc (or fake-complete if misaligned)
  localparam logic [1:0] S_HOLD = 2'd1;  // word parked in hold buffer, bus idle
  localparam logic [1:0] S_DROP = 2'd2;  // waiting out an orphaned request

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;
  logic [31:0] r_hold_addr;
  logic [31:0] r_hold_inst;
  logic        r_hold_adel;
  logic        r_br_pend;
  logic [31:0] r_br_target;
  logic        r_id_valid;
  logic [31:0] r_id_addr;
  logic [31:0] r_id_inst;
  logic        r_id_adel;

  logic        w_misal;
  logic        w_req_done;
  logic [31:0] w_word_inst;
  logic        w_adv;
  logic [31:0] w_adv_addr;
  logic [31:0] w_adv_inst;
  logic        w_adv_adel;
  logic [31:0] w_nxt;
  logic [31:0] w_pc_adv;

  // A misaligned pc never goes on the bus; it completes at once as an address-error fetch.
  assign w_misal     = (r_pc[1:0] != 2'b00);
  assign w_req_done  = (r_state == S_REQ) && (w_misal || i_rom_ready);
  assign w_word_inst = w_misal ? 32'h0 : i_rom_rdata;

  // w_adv: a fetched word moves into the output register and pc advances.
  assign w_adv      = !i_stall && (((r_state == S_REQ) && w_req_done) || (r_state == S_HOLD));
  assign w_adv_addr = (r_state == S_HOLD) ? r_hold_addr : r_pc;
  assign w_adv_inst = (r_state == S_HOLD) ? r_hold_inst : w_word_inst;
  assign w_adv_adel = (r_state == S_HOLD) ? r_hold_adel : w_misal;
  // After an address error the pc parks on the bad address until a flush.
  assign w_pc_adv   = w_adv_adel ? r_pc : w_nxt;

  assign o_rom_en    = i_rst && (((r_state == S_REQ) && !w_misal) || (r_state == S_DROP));
  assign o_rom_addr  = (r_state == S_DROP) ? r_drop_addr : r_pc;
  assign o_id_valid  = r_id_valid;
  assign o_id_addr   = r_id_addr;
  assign o_id_inst   = r_id_inst;
  assign o_id_adel   = r_id_adel;
  assign o_dbg_state = r_state;

  // Next sequential fetch address; a live branch beats a pending one, which beats pc+4.
  always_comb begin
    w_nxt = r_pc + 32'd4;
    if (i_branch_flag && !i_stall) begin
      w_nxt = i_branch_addr;
    end else if (r_br_pend) begin
      w_nxt = r_br_target;
    end
  end

  // FSM and program counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_drop_addr <= 32'h0;
    end else if (i_flush) begin
      r_pc <= i_flush_pc;
      if ((r_state == S_REQ) && !w_req_done) begin
        r_state     <= S_DROP;
        r_drop_addr <= r_pc;
      end else if ((r_state == S_DROP) && !i_rom_ready) begin
        r_state <= S_DROP;
      end else begin
        // Includes DROP whose old request retires this very cycle.
        r_state <= S_REQ;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_req_done) begin
            if (i_stall) begin
              r_state <= S_HOLD;
            end else begin
              r_pc <= w_pc_adv;
            end
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            r_pc    <= w_pc_adv;
            r_state <= S_REQ;
          end
        end
        S_DROP: begin
          if (i_rom_ready) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  // Hold buffer: captures a completed word that decode cannot take yet.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_hold_addr <= 32'h0;
      r_hold_inst <= 32'h0;
      r_hold_adel <= 1'b0;
    end else if (!i_flush && w_req_done && i_stall) begin
      r_hold_addr <= r_pc;
      r_hold_inst <= w_word_inst;
      r_hold_adel <= w_misal;
    end
  end

  // Pending branch: remembers a redirect resolved before the delay slot finished fetching.
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_flush) begin
      r_br_pend   <= 1'b0;
      r_br_target <= 32'h0;
    end else if (w_adv) begin
      r_br_pend <= 1'b0;
    end else if (i_branch_flag && !i_stall) begin
      r_br_pend   <= 1'b1;
      r_br_target <= i_branch_addr;
    end
  end

  // Output register to decode: new word, bubble, or held value under stall.
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_flush) begin
      r_id_valid <= 1'b0;
      r_id_addr  <= 32'h0;
      r_id_inst  <= 32'h0;
      r_id_adel  <= 1'b0;
    end else if (w_adv) begin
      r_id_valid <= 1'b1;
      r_id_addr  <= w_adv_addr;
      r_id_inst  <= w_adv_inst;
      r_id_adel  <= w_adv_adel;
    end else if (!i_stall) begin
      r_id_valid <= 1'b0;
      r_id_addr  <= 32'h0;
      r_id_inst  <= 32'h0;
      r_id_adel  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed cycle vectors for inst_fetch.
// Each vector gives the inputs for one cycle and the outputs expected during
// that cycle. The ROM returns addr ^ 32'h0F0F0000, so an instruction word can
// be told apart from its address.
module tb_inst_fetch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_addr;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic        rom_ready;
  logic [31:0] rom_rdata;
  logic        id_valid;
  logic [31:0] id_addr;
  logic [31:0] id_inst;
  logic        id_adel;
  logic [1:0]  dbg_state;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h0F0F_0000;
  endfunction

  assign rom_rdata = rom_word(rom_addr);

  inst_fetch dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_stall       (stall),
    .i_flush       (flush),
    .i_flush_pc    (flush_pc),
    .i_branch_flag (branch_flag),
    .i_branch_addr (branch_addr),
    .o_rom_en      (rom_en),
    .o_rom_addr    (rom_addr),
    .i_rom_ready   (rom_ready),
    .i_rom_rdata   (rom_rdata),
    .o_id_valid    (id_valid),
    .o_id_addr     (id_addr),
    .o_id_inst     (id_inst),
    .o_id_adel     (id_adel),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] fpc;
    logic        bf;
    logic [31:0] ba;
    logic        rdy;
    logic        e_en;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_id;
    logic        e_adel;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic [31:0] fpc,
                              input logic bf, input logic [31:0] ba, input logic rdy,
                              input logic e_en, input logic [31:0] e_addr,
                              input logic e_v, input logic [31:0] e_id, input logic e_adel);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.fpc = fpc; v.bf = bf; v.ba = ba; v.rdy = rdy;
    v.e_en = e_en; v.e_addr = e_addr; v.e_v = e_v; v.e_id = e_id; v.e_adel = e_adel;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  // Entered just after a rising edge: drive, check at the falling edge, then advance.
  task automatic run_vec(input string tag, input int idx, input vec_t v);
    logic [31:0] e_inst;
    rst         = v.rst;
    stall       = v.stall;
    flush       = v.flush;
    flush_pc    = v.fpc;
    branch_flag = v.bf;
    branch_addr = v.ba;
    rom_ready   = v.rdy;
    e_inst = (v.e_v && !v.e_adel) ? rom_word(v.e_id) : 32'h0;
    @(negedge clk);
    chk($sformatf("%s[%0d].rom_en", tag, idx), {31'h0, rom_en}, {31'h0, v.e_en});
    if (v.e_en) chk($sformatf("%s[%0d].rom_addr", tag, idx), rom_addr, v.e_addr);
    chk($sformatf("%s[%0d].id_valid", tag, idx), {31'h0, id_valid}, {31'h0, v.e_v});
    chk($sformatf("%s[%0d].id_addr", tag, idx), id_addr, v.e_v ? v.e_id : 32'h0);
    chk($sformatf("%s[%0d].id_inst", tag, idx), id_inst, e_inst);
    chk($sformatf("%s[%0d].id_adel", tag, idx), {31'h0, id_adel}, {31'h0, v.e_adel});
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = 32'h0;
    branch_flag = 1'b0; branch_addr = 32'h0; rom_ready = 1'b0;

    //                   rst s  f  fpc            bf ba        rdy en addr          v  id            adel
    // streaming from reset, rom_ready tied high
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  1, 32'hBFC0_0000, 0, 32'h0,         0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  1, 32'hBFC0_0004, 1, 32'hBFC0_0000, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  1, 32'hBFC0_0008, 1, 32'hBFC0_0004, 0));
    // flush to 0x100, then branch at 0x100 -> 0x400 with the delay slot completing at once
    tbl.push_back(mk(1, 0, 1, 32'h100,        0, 32'h0,   1,  1, 32'hBFC0_000C, 1, 32'hBFC0_0008, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  1, 32'h100,       0, 32'h0,         0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          1, 32'h400, 1,  1, 32'h104,       1, 32'h100,       0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  1, 32'h400,       1, 32'h104,       0));
    // same branch, delay slot returns 3 cycles late
    tbl.push_back(mk(1, 0, 1, 32'h100,        0, 32'h0,   1,  1, 32'h404,       1, 32'h400,       0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  1, 32'h100,       0, 32'h0,         0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          1, 32'h400, 0,  1, 32'h104,       1, 32'h100,       0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   0,  1, 32'h104,       0, 32'h0,         0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   0,  1, 32'h104,       0, 32'h0,         0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  1, 32'h104,       0, 32'h0,         0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  1, 32'h400,       1, 32'h104,       0));
    // stall held 4 cycles while 0x208 returns
    tbl.push_back(mk(1, 0, 1, 32'h200,        0, 32'h0,   1,  1, 32'h404,       1, 32'h400,       0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  1, 32'h200,       0, 32'h0,         0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  1, 32'h204,       1, 32'h200,       0));
    tbl.push_back(mk(1, 1, 0, 32'h0,          0, 32'h0,   1,  1, 32'h208,       1, 32'h204,       0));
    tbl.push_back(mk(1, 1, 0, 32'h0,          0, 32'h0,   1,  0, 32'h0,         1, 32'h204,       0));
    tbl.push_back(mk(1, 1, 0, 32'h0,          0, 32'h0,   1,  0, 32'h0,         1, 32'h204,       0));
    tbl.push_back(mk(1, 1, 0, 32'h0,          0, 32'h0,   1,  0, 32'h0,         1, 32'h204,       0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  0, 32'h0,         1, 32'h204,       0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  1, 32'h20C,       1, 32'h208,       0));
    // flush to 0xBFC00380 while 0x300 is still outstanding for 2 more cycles
    tbl.push_back(mk(1, 0, 1, 32'h300,        0, 32'h0,   1,  1, 32'h210,       1, 32'h20C,       0));
    tbl.push_back(mk(1, 0, 1, 32'hBFC0_0380,  0, 32'h0,   0,  1, 32'h300,       0, 32'h0,         0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   0,  1, 32'h300,       0, 32'h0,         0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  1, 32'h300,       0, 32'h0,         0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  1, 32'hBFC0_0380, 0, 32'h0,         0));
    // branch to misaligned 0x402
    tbl.push_back(mk(1, 0, 1, 32'h100,        0, 32'h0,   1,  1, 32'hBFC0_0384, 1, 32'hBFC0_0380, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  1, 32'h100,       0, 32'h0,         0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          1, 32'h402, 1,  1, 32'h104,       1, 32'h100,       0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  0, 32'h0,         1, 32'h104,       0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  0, 32'h0,         1, 32'h402,       1));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,   1,  0, 32'h0,         1, 32'h402,       1));

    @(posedge clk);
    #1;

    // hand sequence: power-on reset, two cycles low
    run_vec("por", 0, mk(0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 0));
    run_vec("por", 1, mk(0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 0));

    for (int i = 0; i < tbl.size(); i++) run_vec("vec", i, tbl[i]);

    // hand sequence: reset while in HOLD with a branch pending to 0x400
    run_vec("mrst", 0,  mk(1, 0, 1, 32'h100, 0, 32'h0,   1, 0, 32'h0,         1, 32'h402,       1));
    run_vec("mrst", 1,  mk(1, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h100,       0, 32'h0,         0));
    run_vec("mrst", 2,  mk(1, 0, 0, 32'h0,   1, 32'h400, 0, 1, 32'h104,       1, 32'h100,       0));
    run_vec("mrst", 3,  mk(1, 1, 0, 32'h0,   0, 32'h0,   1, 1, 32'h104,       0, 32'h0,         0));
    run_vec("mrst", 4,  mk(0, 1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,         0, 32'h0,         0));
    run_vec("mrst", 5,  mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,         0, 32'h0,         0));
    run_vec("mrst", 6,  mk(1, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'hBFC0_0000, 0, 32'h0,         0));
    run_vec("mrst", 7,  mk(1, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'hBFC0_0004, 1, 32'hBFC0_0000, 0));
    // hand sequence: reset with a valid instruction in the output register
    run_vec("mrst", 8,  mk(0, 0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,         1, 32'hBFC0_0004, 0));
    run_vec("mrst", 9,  mk(1, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'hBFC0_0000, 0, 32'h0,         0));
    run_vec("mrst", 10, mk(1, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'hBFC0_0004, 1, 32'hBFC0_0000, 0));

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
